// File: rtl/jump_ctrl.sv
// -----------------------------------------------------------------------------
// jump_ctrl
//
// Button front-end and jump-request handshake for the player character.
// The raw button is synchronised and debounced. A press starts a charge
// whose distance grows once per animation tick up to a ceiling. The release
// freezes the distance and raises a jump request. The game FSM consumes the
// request with jump_ack, and the controller then waits until the game is idle
// and the button is released before it accepts another press.
//
// Parameters
//   DEB_CYCLES : consecutive mismatching synchronised samples needed before
//                the debounced level follows the button
//   TICK_DIV   : clk cycles per anim_tick pulse
//   CHARGE_MIN : distance loaded when charging starts
//   CHARGE_MAX : saturation ceiling of the distance
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_btn        : raw, asynchronous player button
//   i_busy       : game FSM is animating; new presses are ignored
//   i_jump_ack   : game FSM has consumed o_jump_dist
//   o_anim_tick  : one-cycle animation step strobe, free-running
//   o_jump_req   : jump request, held until acknowledged
//   o_jump_dist  : requested jump distance (unsigned)
//   o_charging   : high while a charge is in progress (power bar)
// -----------------------------------------------------------------------------
module jump_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 16,
  parameter int CHARGE_MIN = 13,
  parameter int CHARGE_MAX = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  input  logic       i_busy,
  input  logic       i_jump_ack,
  output logic       o_anim_tick,
  output logic       o_jump_req,
  output logic [7:0] o_jump_dist,
  output logic       o_charging
);

  localparam int SYNC_STAGES = 2;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [7:0]    CHG_MIN   = 8'(CHARGE_MIN);
  localparam logic [7:0]    CHG_MAX   = 8'(CHARGE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHARGE,
    ST_REQ,
    ST_LOCK
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous button
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debouncer: the counter tracks how many consecutive samples disagree with
  // the current debounced level; a single agreeing sample clears it.
  // r_btn_db_d is the previous debounced level, used for edge detection.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_deb_cnt;
  logic          r_btn_db;
  logic          r_btn_db_d;
  logic          w_mismatch;

  assign w_mismatch = w_sync ^ r_btn_db;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb_cnt  <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
    end else begin
      r_btn_db_d <= r_btn_db;
      if (w_mismatch) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_btn_db  <= w_sync;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Animation tick divider. The strobe is registered from the next count so
  // that it is high in exactly the cycle the count sits at TICK_DIV-1.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] r_tick_cnt;
  logic [TW-1:0] w_tick_cnt_next;
  logic          r_anim_tick;

  assign w_tick_cnt_next = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt  <= '0;
      r_anim_tick <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick_cnt_next;
      r_anim_tick <= (w_tick_cnt_next == TICK_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Jump state machine. The distance register doubles as the charge
  // accumulator, so it only moves on entry to CHARGE and on ticks in CHARGE.
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic       r_jump_req;
  logic       r_charging;
  logic [7:0] r_jump_dist;
  logic       w_db_rise;
  logic       w_db_fall;
  logic [7:0] w_charge_inc;
  logic [7:0] w_charge_step;

  assign w_db_rise = r_btn_db & ~r_btn_db_d;
  assign w_db_fall = ~r_btn_db & r_btn_db_d;

  // Saturating increment; a tick that lands on the release cycle still counts.
  assign w_charge_inc  = (r_jump_dist < CHG_MAX) ? (r_jump_dist + 8'd1) : CHG_MAX;
  assign w_charge_step = r_anim_tick ? w_charge_inc : r_jump_dist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_jump_req  <= 1'b0;
      r_charging  <= 1'b0;
      r_jump_dist <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Edges arriving while busy are simply dropped, not queued.
          if (w_db_rise && !i_busy) begin
            r_state     <= ST_CHARGE;
            r_jump_dist <= CHG_MIN;
            r_charging  <= 1'b1;
          end
        end
        ST_CHARGE: begin
          // busy is deliberately not looked at: a started charge completes.
          r_jump_dist <= w_charge_step;
          if (w_db_fall) begin
            r_state    <= ST_REQ;
            r_charging <= 1'b0;
            r_jump_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_jump_ack) begin
            r_state    <= ST_LOCK;
            r_jump_req <= 1'b0;
          end
        end
        ST_LOCK: begin
          // Requiring the button released prevents a held button from
          // starting a new charge as soon as the game goes idle.
          if (!i_busy && !r_btn_db) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_jump_req <= 1'b0;
          r_charging <= 1'b0;
        end
      endcase
    end
  end

  assign o_anim_tick = r_anim_tick;
  assign o_jump_req  = r_jump_req;
  assign o_jump_dist = r_jump_dist;
  assign o_charging  = r_charging;

endmodule

// File: tb/tb_jump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jump_ctrl
//
// Drives jump_ctrl with directed scenarios and a randomised run, comparing
// outputs against a behavioural model of the controller. The model tracks
// the button through a two-sample delay queue, a run-length debouncer, a
// global cycle count for the tick, and derives the distance as
// min(CHARGE_MAX, CHARGE_MIN + ticks seen while charging).
// -----------------------------------------------------------------------------
module tb_jump_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 16;
  localparam int CMIN = 13;
  localparam int CMAX = 20;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       busy;
  logic       jump_ack;
  logic       o_anim_tick;
  logic       o_jump_req;
  logic [7:0] o_jump_dist;
  logic       o_charging;

  int n_tests;
  int n_fail;

  jump_ctrl #(
    .DEB_CYCLES (DEB),
    .TICK_DIV   (TDIV),
    .CHARGE_MIN (CMIN),
    .CHARGE_MAX (CMAX)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn       (btn),
    .i_busy      (busy),
    .i_jump_ack  (jump_ack),
    .o_anim_tick (o_anim_tick),
    .o_jump_req  (o_jump_req),
    .o_jump_dist (o_jump_dist),
    .o_charging  (o_charging)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model. Modes: 0 idle, 1 charging, 2 requesting, 3 locked.
  // ---------------------------------------------------------------------------
  int m_mode;
  int m_ticks;
  int m_dist;
  int m_db;
  int m_db_prev;
  int m_run;
  int m_cyc;
  int m_tick;
  int m_q[$];

  function automatic void model_reset();
    m_mode    = 0;
    m_ticks   = 0;
    m_dist    = 0;
    m_db      = 0;
    m_db_prev = 0;
    m_run     = 0;
    m_cyc     = 0;
    m_tick    = 0;
    m_q       = '{0, 0};
  endfunction

  // Advance the model across one rising edge with the inputs seen there.
  function automatic void model_advance(input int b, input int bz, input int ak);
    int  sync_val;
    bit  rise;
    bit  fall;
    rise = (m_db == 1) && (m_db_prev == 0);
    fall = (m_db == 0) && (m_db_prev == 1);
    case (m_mode)
      0: if (rise && bz == 0) begin
           m_mode  = 1;
           m_ticks = 0;
           m_dist  = CMIN;
         end
      1: begin
           if (m_tick != 0) m_ticks++;
           m_dist = (CMIN + m_ticks > CMAX) ? CMAX : CMIN + m_ticks;
           if (fall) m_mode = 2;
         end
      2: if (ak != 0) m_mode = 3;
      default: if (bz == 0 && m_db == 0) m_mode = 0;
    endcase
    // Button as seen after two synchroniser stages.
    sync_val = m_q.pop_front();
    m_q.push_back(b);
    m_db_prev = m_db;
    if (sync_val != m_db) begin
      m_run++;
      if (m_run == DEB) begin
        m_db  = sync_val;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_cyc++;
    m_tick = ((m_cyc % TDIV) == TDIV - 1) ? 1 : 0;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic b, input logic bz, input logic ak);
    btn      = b;
    busy     = bz;
    jump_ack = ak;
    @(posedge clk);
    model_advance(int'(b), int'(bz), int'(ak));
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (o_jump_req !== 1'b0 || o_charging !== 1'b0 || o_anim_tick !== 1'b0 ||
        o_jump_dist !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b chg=%b tick=%b dist=%0d, required all 0",
               o_jump_req, o_charging, o_anim_tick, o_jump_dist);
    end
    rst_n = 1'b1;
    // Tick is high in the cycle ending at the TICK_DIV-th edge after release.
    for (int k = 1; k <= TDIV + 2; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_anim_tick !== ((k % TDIV) == TDIV - 1)) begin
        n_fail++;
        $display("FAIL first_tick: after edge %0d got tick=%b required %b",
                 k, o_anim_tick, ((k % TDIV) == TDIV - 1));
      end
    end
    $display("[TB] test_reset done");
  endtask

  // Press, count 5 ticks in charge, release: distance 18.
  task automatic test_charge();
    int guard;
    int cyc;
    int db_fall_cyc;
    int chg_fall_cyc;
    guard = 0;
    while (!(m_mode == 1 && m_ticks == 5) && guard < 300) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL charge_wait: got %0d ticks in charge, required 5", m_ticks);
    end
    cyc = 0; guard = 0; db_fall_cyc = -1; chg_fall_cyc = -1;
    while (m_mode != 2 && guard < 40) begin
      cycle(1'b0, 1'b0, 1'b0);
      cyc++; guard++;
      if (db_fall_cyc < 0 && m_db == 0) db_fall_cyc = cyc;
      if (chg_fall_cyc < 0 && o_charging === 1'b0) chg_fall_cyc = cyc;
    end
    n_tests++;
    if (o_jump_req !== 1'b1 || o_jump_dist !== 8'd18) begin
      n_fail++;
      $display("FAIL charge_req: got req=%b dist=%0d, required req=1 dist=18",
               o_jump_req, o_jump_dist);
    end
    n_tests++;
    if (chg_fall_cyc != db_fall_cyc + 1) begin
      n_fail++;
      $display("FAIL charging_fall: got charging low at cycle %0d, required %0d",
               chg_fall_cyc, db_fall_cyc + 1);
    end
    cycle(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_jump_req !== 1'b0 || o_jump_dist !== 8'd18) begin
      n_fail++;
      $display("FAIL ack_lock: got req=%b dist=%0d, required req=0 dist=18",
               o_jump_req, o_jump_dist);
    end
    cycle(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (m_mode != 0 || o_charging !== 1'b0 || o_jump_dist !== 8'd18) begin
      n_fail++;
      $display("FAIL back_idle: got chg=%b dist=%0d, required chg=0 dist=18",
               o_charging, o_jump_dist);
    end
    $display("[TB] test_charge done");
  endtask

  // Hold through 12 ticks: distance must stop at CHARGE_MAX.
  task automatic test_saturate();
    int guard;
    guard = 0;
    while (!(m_mode == 1 && m_ticks == 12) && guard < 600) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
      if (m_mode == 1) begin
        n_tests++;
        if (o_jump_dist !== 8'(m_dist)) begin
          n_fail++;
          $display("FAIL sat_ramp: got dist=%0d required %0d", o_jump_dist, m_dist);
        end
      end
    end
    guard = 0;
    while (m_mode != 2 && guard < 40) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (o_jump_req !== 1'b1 || o_jump_dist !== 8'(CMAX)) begin
      n_fail++;
      $display("FAIL saturate: got req=%b dist=%0d, required req=1 dist=%0d",
               o_jump_req, o_jump_dist, CMAX);
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    $display("[TB] test_saturate done");
  endtask

  // Two-cycle glitch must not disturb anything.
  task automatic test_glitch();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_charging !== 1'b0 || o_jump_req !== 1'b0 || o_jump_dist !== 8'(CMAX)) begin
        n_fail++;
        $display("FAIL glitch: got chg=%b req=%b dist=%0d, required 0 0 %0d",
                 o_charging, o_jump_req, o_jump_dist, CMAX);
      end
    end
    $display("[TB] test_glitch done");
  endtask

  // Full press while busy, release, then busy drops: nothing happens.
  task automatic test_busy_press();
    for (int i = 0; i < 52; i++) begin
      if (i < 20)      cycle(1'b1, 1'b1, 1'b0);
      else if (i < 32) cycle(1'b0, 1'b1, 1'b0);
      else             cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_charging !== 1'b0 || o_jump_req !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_press: cycle %0d got chg=%b req=%b, required 0 0",
                 i, o_charging, o_jump_req);
      end
    end
    $display("[TB] test_busy_press done");
  endtask

  // Delayed ack with a re-press during the wait.
  task automatic test_ack_delay();
    int guard;
    int want_ticks;
    int exp_dist;
    want_ticks = int'($urandom_range(1, 3));
    guard = 0;
    while (!(m_mode == 1 && m_ticks == want_ticks) && guard < 200) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    guard = 0;
    while (m_mode != 2 && guard < 40) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    exp_dist = CMIN + want_ticks;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, (i >= 5), 1'b0);
      n_tests++;
      if (o_jump_req !== 1'b1 || o_jump_dist !== 8'(exp_dist) || o_charging !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_wait: cycle %0d got req=%b dist=%0d chg=%b, required 1 %0d 0",
                 i, o_jump_req, o_jump_dist, o_charging, exp_dist);
      end
    end
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (o_jump_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_drop: got req=%b required 0", o_jump_req);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (o_jump_req !== 1'b0 || o_charging !== 1'b0 || o_jump_dist !== 8'(exp_dist)) begin
        n_fail++;
        $display("FAIL lock_hold: cycle %0d got req=%b chg=%b dist=%0d, required 0 0 %0d",
                 i, o_jump_req, o_charging, o_jump_dist, exp_dist);
      end
    end
    guard = 0;
    while (m_mode != 0 && guard < 30) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    // A fresh press must now start a charge, proving the return to idle.
    guard = 0;
    while (o_charging !== 1'b1 && guard < 30) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (o_charging !== 1'b1 || o_jump_dist !== 8'(CMIN)) begin
      n_fail++;
      $display("FAIL repress_idle: got chg=%b dist=%0d, required 1 %0d",
               o_charging, o_jump_dist, CMIN);
    end
    guard = 0;
    while (m_mode != 2 && guard < 40) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    $display("[TB] test_ack_delay done");
  endtask

  // Reset in the middle of a charge and of a request.
  task automatic test_reset_mid();
    int guard;
    for (int v = 0; v < 2; v++) begin
      guard = 0;
      while (m_mode != v + 1 && guard < 60) begin
        cycle((v == 0) || (m_mode == 0), 1'b0, 1'b0);
        guard++;
      end
      btn = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (o_jump_req !== 1'b0 || o_jump_dist !== 8'd0 || o_charging !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset: variant %0d got req=%b dist=%0d chg=%b, required 0 0 0",
                 v, o_jump_req, o_jump_dist, o_charging);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
        cycle(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_jump_req !== 1'b0 || o_charging !== 1'b0) begin
          n_fail++;
          $display("FAIL post_reset: variant %0d cycle %0d got req=%b chg=%b, required 0 0",
                   v, i, o_jump_req, o_charging);
        end
      end
    end
    $display("[TB] test_reset_mid done");
  endtask

  // Random button/busy/ack traffic, every cycle checked against the model.
  task automatic test_random();
    logic b;
    logic bz;
    int   b_run;
    int   bz_run;
    b = 1'b0; bz = 1'b0; b_run = 5; bz_run = 10;
    for (int i = 0; i < 1500; i++) begin
      if (b_run == 0) begin
        b = ~b;
        b_run = int'($urandom_range(1, 70));
      end
      if (bz_run == 0) begin
        bz = ~bz;
        bz_run = int'($urandom_range(1, 40));
      end
      b_run--; bz_run--;
      cycle(b, bz, ($urandom_range(0, 3) == 0));
      n_tests++;
      if (o_jump_req !== (m_mode == 2) || o_charging !== (m_mode == 1) ||
          o_jump_dist !== 8'(m_dist) || o_anim_tick !== (m_tick != 0)) begin
        n_fail++;
        $display("FAIL random: cycle %0d got req=%b chg=%b dist=%0d tick=%b, required %b %b %0d %b",
                 i, o_jump_req, o_charging, o_jump_dist, o_anim_tick,
                 (m_mode == 2), (m_mode == 1), m_dist, (m_tick != 0));
      end
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    btn      = 1'b0;
    busy     = 1'b0;
    jump_ack = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    test_reset();
    test_charge();
    test_saturate();
    test_glitch();
    test_busy_press();
    test_ack_delay();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples needed before the debounced level changes.
REQ-002 Parameter TICK_DIV, default 16: clk cycles per anim_tick pulse.
REQ-003 Parameter CHARGE_MIN, default 13: jump distance loaded when charging starts.
REQ-004 Parameter CHARGE_MAX, default 20: saturation ceiling of jump distance.
REQ-005 clk  input  1  single clock; all logic clocked on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn  input  1  raw asynchronous player button.
REQ-008 busy  input  1  game FSM animating (shift/jump/fall); high blocks new presses.
REQ-009 jump_ack  input  1  game FSM has consumed jump_dist.
REQ-010 anim_tick  output  1  one-cycle animation step strobe.
REQ-011 jump_req  output  1  jump request, held until acknowledged.
REQ-012 jump_dist  output  8  requested jump distance, unsigned.
REQ-013 charging  output  1  high while in CHARGE (power-bar display).

Function
REQ-014 btn shall pass through a 2-flop synchronizer; the debounced level btn_db shall take the synchronized value only after it differs from btn_db for DEB_CYCLES consecutive cycles; any mismatch-free sample shall clear the counter.
REQ-015 Tick divider shall count 0..TICK_DIV-1 and wrap; anim_tick shall be high exactly in the cycle the count equals TICK_DIV-1, free-running in every state.
REQ-016 State machine shall have states IDLE, CHARGE, REQ, LOCK.
REQ-017 IDLE -> CHARGE on btn_db rising edge when busy=0; charge register loaded with CHARGE_MIN on that transition.
REQ-018 A btn_db rising edge with busy=1 shall be ignored and not remembered; a new edge after busy falls is required.
REQ-019 In CHARGE, each anim_tick shall increment charge by 1, saturating at CHARGE_MAX (no wrap).
REQ-020 CHARGE -> REQ on btn_db falling edge; if a tick coincides with the falling edge, the increment shall still be applied before the value is frozen.
REQ-021 In REQ, jump_req=1 and jump_dist=charge, both stable until jump_ack is sampled high; REQ -> LOCK on that cycle; jump_req low from the next cycle.
REQ-022 jump_ack while jump_req=0 shall be ignored.
REQ-023 LOCK -> IDLE when busy=0 and btn_db=0 in the same cycle; presses during LOCK shall be ignored.
REQ-024 jump_dist shall hold its last value in LOCK and IDLE and update only on entry to CHARGE and on ticks in CHARGE.
REQ-025 charging shall be registered and equal 1 exactly while state is CHARGE.
REQ-026 busy rising during CHARGE shall not abort charging; the request shall still be issued.

Reset
REQ-027 rst_n low shall immediately force state IDLE, jump_req=0, jump_dist=0, charging=0, anim_tick=0, tick count 0, debounce counter 0, btn_db=0, synchronizer flops 0.
REQ-028 Reset asserted mid-CHARGE or mid-REQ shall discard the pending request; after release, a fresh btn_db rising edge is required.
REQ-029 After rst_n deasserts, the first anim_tick shall occur on the TICK_DIV-th rising clk edge.

Verification
REQ-030 btn high, busy=0, released after 5 anim_ticks counted in CHARGE -> jump_req=1, jump_dist=18, charging falls one cycle after btn_db falls.
REQ-031 btn held through 12 ticks -> jump_dist saturates at 20, no wrap to 0 or 13.
REQ-032 btn glitches high for 2 cycles (< DEB_CYCLES) -> btn_db, state and all outputs unchanged.
REQ-033 Full press/release while busy=1, then busy falls with btn low -> no jump_req, state remains IDLE.
REQ-034 jump_ack delayed 10 cycles, btn re-pressed during wait -> jump_req and jump_dist stable for all 10 cycles; LOCK entered on ack; re-press ignored; IDLE entered once busy=0 and btn_db=0.
REQ-035 rst_n pulsed low while jump_req=1 -> jump_req=0 and jump_dist=0 asynchronously before the next clk edge; no request after release without a new press.
